// File: rtl/ghash_sequencer.sv
// ----------------------------------------------------------------------------
// ghash_sequencer
//
// Drives an external GF(2^128) multiply-and-reduce unit (GCM bit order,
// polynomial 0xE1 || 0^120) to compute GHASH over a stream of 128-bit
// blocks: Y_i = (Y_{i-1} XOR X_i) * H, with Y_0 = 0. The block owns the
// hash key register, the running accumulator, the block and tag handshakes
// and the start/done protocol towards the multiplier.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   h_valid      load h_data into the key register (IDLE only)
//   h_data       hash key H
//   clr          clear accumulator and block counter (IDLE only)
//   s_valid      input block valid
//   s_ready      input block accepted when s_valid & s_ready
//   s_data       input block X_i
//   s_last       final block of the current message
//   mul_start    one-cycle pulse launching a multiply
//   mul_a        operand A = acc XOR X_i, stable until mul_done
//   mul_b        operand B = H, stable until mul_done
//   mul_done     one-cycle pulse, mul_res valid
//   mul_res      reduced product
//   tag_valid    GHASH result valid, held until tag_ready
//   tag_ready    downstream accepts the tag
//   tag_data     GHASH result
//   blk_count    blocks completed in the current message (saturating)
//   h_loaded     a key has been loaded since reset
//   busy         sequencer is not in IDLE
// ----------------------------------------------------------------------------
module ghash_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             h_valid,
  input  logic [127:0]     h_data,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [127:0]     s_data,
  input  logic             s_last,
  output logic             mul_start,
  output logic [127:0]     mul_a,
  output logic [127:0]     mul_b,
  input  logic             mul_done,
  input  logic [127:0]     mul_res,
  output logic             tag_valid,
  input  logic             tag_ready,
  output logic [127:0]     tag_data,
  output logic [CNT_W-1:0] blk_count,
  output logic             h_loaded,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    OUTPUT   = 2'd2
  } state_t;

  state_t       state;
  logic [127:0] acc;
  logic [127:0] h_reg;
  logic         last_r;

  // Key load and clear win over block acceptance, so a block is never
  // hashed against a key or accumulator that is changing in the same cycle.
  assign s_ready = (state == IDLE) & h_loaded & ~h_valid & ~clr;
  assign busy    = (state != IDLE);

  // NOTE: all state uses non-blocking assignments so every branch below
  // reads the pre-edge values of acc, h_reg and blk_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the 128-bit key and accumulator are plain registers, not a
      // memory, so they are reset together with the control state.
      state     <= IDLE;
      acc       <= '0;
      h_reg     <= '0;
      last_r    <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      tag_valid <= 1'b0;
      tag_data  <= '0;
      blk_count <= '0;
      h_loaded  <= 1'b0;
    end else begin
      // mul_start is a single-cycle pulse.
      mul_start <= 1'b0;

      case (state)
        IDLE: begin
          if (h_valid) begin
            h_reg    <= h_data;
            h_loaded <= 1'b1;
          end
          if (clr) begin
            acc       <= '0;
            blk_count <= '0;
          end
          if (s_valid && s_ready) begin
            mul_a     <= acc ^ s_data;
            mul_b     <= h_reg;
            mul_start <= 1'b1;
            last_r    <= s_last;
            state     <= MUL_WAIT;
          end
        end

        // Only one multiply is ever outstanding: the next block needs this
        // result as its accumulator. A mul_done coinciding with mul_start
        // (zero-latency multiplier) lands here and is taken as this result.
        MUL_WAIT: begin
          if (mul_done) begin
            acc <= mul_res;
            if (blk_count != '1) begin
              blk_count <= blk_count + 1'b1;
            end
            if (last_r) begin
              tag_data  <= mul_res;
              tag_valid <= 1'b1;
              state     <= OUTPUT;
            end else begin
              state <= IDLE;
            end
          end
        end

        // Tag is held until taken; the next message restarts from Y_0 = 0.
        OUTPUT: begin
          if (tag_ready) begin
            tag_valid <= 1'b0;
            acc       <= '0;
            blk_count <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ghash_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ghash_sequencer
//
// Directed bench for ghash_sequencer. A behavioural GF(2^128) multiplier
// with programmable latency answers mul_start; a second instance with
// CNT_W = 2 runs in lockstep to exercise counter saturation.
// ----------------------------------------------------------------------------
module tb_ghash_sequencer;

  localparam logic [127:0] H_ID   = {1'b1, 127'h0};  // GF identity in GCM order
  localparam logic [127:0] H_X    = {2'b01, 126'h0}; // multiply by x
  localparam logic [127:0] H_NIST = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C_NIST = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] L_NIST = 128'h00000000000000000000000000000080;
  localparam logic [127:0] T_NIST = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         h_valid = 1'b0;
  logic [127:0] h_data = '0;
  logic         clr = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         mul_start;
  logic [127:0] mul_a, mul_b;
  logic         mul_done;
  logic [127:0] mul_res;
  logic         tag_valid;
  logic         tag_ready = 1'b0;
  logic [127:0] tag_data;
  logic [15:0]  blk_count;
  logic         h_loaded;
  logic         busy;

  logic         sat_s_ready, sat_mul_start, sat_tag_valid, sat_h_loaded, sat_busy;
  logic [127:0] sat_mul_a, sat_mul_b, sat_tag_data;
  logic [1:0]   sat_blk_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ghash_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_data(h_data), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_res(mul_res),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_data(tag_data),
    .blk_count(blk_count), .h_loaded(h_loaded), .busy(busy)
  );

  ghash_sequencer #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_data(h_data), .clr(clr),
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data), .s_last(s_last),
    .mul_start(sat_mul_start), .mul_a(sat_mul_a), .mul_b(sat_mul_b),
    .mul_done(mul_done), .mul_res(mul_res),
    .tag_valid(sat_tag_valid), .tag_ready(tag_ready), .tag_data(sat_tag_data),
    .blk_count(sat_blk_count), .h_loaded(sat_h_loaded), .busy(sat_busy)
  );

  // Reference GCM multiply (bit 127 is coefficient x^0).
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'h0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // Multiplier model: mul_done appears L cycles after the mul_start cycle.
  int           lat = 3;
  logic         model_done = 1'b0;
  logic [127:0] model_res = '0;
  logic         pending = 1'b0;
  int           cnt = 0;
  logic [127:0] op_a = '0, op_b = '0;
  logic         inj_done = 1'b0;
  logic [127:0] inj_res = '0;

  assign mul_done = model_done | inj_done;
  assign mul_res  = inj_done ? inj_res : model_res;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (pending) begin
      if (cnt == 0) begin
        model_done = 1'b1;
        model_res  = gf_mult(op_a, op_b);
        pending    = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (mul_start) begin
      if (lat == 0) begin
        model_done = 1'b1;
        model_res  = gf_mult(mul_a, mul_b);
      end else begin
        pending = 1'b1;
        cnt     = lat - 1;
        op_a    = mul_a;
        op_b    = mul_b;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    h_valid = 1'b1;
    h_data  = k;
    tick();
    h_valid = 1'b0;
  endtask

  // Present a block, wait for acceptance, return what the multiplier sees.
  task automatic send_block(input logic [127:0] d, input logic last,
                            output logic [127:0] a_obs, output logic [127:0] b_obs,
                            output logic st_obs);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    #1;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL s_ready_timeout: got %b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    a_obs   = mul_a;
    b_obs   = mul_b;
    st_obs  = mul_start;
  endtask

  task automatic wait_tag(output int edges);
    int n;
    n = 0;
    while (!tag_valid && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (tag_valid !== 1'b1) begin
      errors++;
      $display("FAIL tag_timeout: got %b expected 1", tag_valid);
    end
    edges = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: got %b expected 0", busy);
    end
  endtask

  task automatic accept_tag();
    tag_ready = 1'b1;
    tick();
    tag_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 128'h1;
    repeat (3) tick();
    checks++;
    if ({s_ready, h_loaded, busy, mul_start, tag_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {s_ready, h_loaded, busy, mul_start, tag_valid});
    end
    checks++;
    if ({mul_a, mul_b, tag_data} !== '0 || blk_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got a=%h b=%h tag=%h cnt=%0d expected zeros",
               mul_a, mul_b, tag_data, blk_count);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL no_key_ready: got %b expected 0", s_ready);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_identity_chain();
    logic [127:0] a, b;
    logic st;
    int e;
    lat = 3;
    load_key(H_ID);
    checks++;
    if (h_loaded !== 1'b1) begin
      errors++;
      $display("FAIL h_loaded: got %b expected 1", h_loaded);
    end
    send_block(128'h1, 1'b0, a, b, st);
    checks++;
    if (a !== 128'h1 || b !== H_ID || st !== 1'b1) begin
      errors++;
      $display("FAIL chain_op1: got a=%h b=%h start=%b expected a=1 b=%h start=1", a, b, st, H_ID);
    end
    send_block(128'h2, 1'b0, a, b, st);
    checks++;
    if (a !== 128'h3) begin
      errors++;
      $display("FAIL chain_op2: got %h expected 3", a);
    end
    send_block(128'h4, 1'b1, a, b, st);
    checks++;
    if (a !== 128'h7) begin
      errors++;
      $display("FAIL chain_op3: got %h expected 7", a);
    end
    wait_tag(e);
    // Handshake edge to tag edge is L+1 edges (tag at t+2+L counting cycles).
    checks++;
    if (e != 4) begin
      errors++;
      $display("FAIL chain_latency: got %0d expected 4", e);
    end
    checks++;
    if (tag_data !== 128'h7 || blk_count !== 16'd3) begin
      errors++;
      $display("FAIL chain_tag: got tag=%h cnt=%0d expected tag=7 cnt=3", tag_data, blk_count);
    end
    accept_tag();
    checks++;
    if (tag_valid !== 1'b0 || blk_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chain_accept: got valid=%b cnt=%0d busy=%b expected 0 0 0",
               tag_valid, blk_count, busy);
    end
  endtask

  task automatic test_nist();
    logic [127:0] a, b;
    logic st;
    int e;
    lat = 5;
    load_key(H_NIST);
    send_block(C_NIST, 1'b0, a, b, st);
    send_block(L_NIST, 1'b1, a, b, st);
    wait_tag(e);
    checks++;
    if (tag_data !== T_NIST) begin
      errors++;
      $display("FAIL nist_tag: got %h expected %h", tag_data, T_NIST);
    end
    accept_tag();
  endtask

  task automatic test_tag_stall();
    logic [127:0] a, b;
    logic st;
    int e;
    int bad;
    lat = 2;
    load_key(H_ID);
    send_block(128'hdead, 1'b1, a, b, st);
    wait_tag(e);
    bad = 0;
    s_valid = 1'b1;
    s_data  = 128'h99;
    h_valid = 1'b1;
    h_data  = H_X;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tag_data !== 128'hdead || tag_valid !== 1'b1 || s_ready !== 1'b0) bad++;
    end
    s_valid = 1'b0;
    h_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    accept_tag();
    send_block(128'h5, 1'b1, a, b, st);
    checks++;
    if (a !== 128'h5 || b !== H_ID) begin
      errors++;
      $display("FAIL stall_restart: got a=%h b=%h expected a=5 b=%h", a, b, H_ID);
    end
    wait_tag(e);
    checks++;
    if (tag_data !== 128'h5) begin
      errors++;
      $display("FAIL stall_next_tag: got %h expected 5", tag_data);
    end
    accept_tag();
  endtask

  task automatic test_key_priority();
    int e;
    lat = 2;
    inj_res  = '1;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || tag_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: got busy=%b valid=%b expected 0 0", busy, tag_valid);
    end
    h_valid = 1'b1;
    h_data  = H_X;
    s_valid = 1'b1;
    s_data  = 128'h10;
    s_last  = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL key_priority: got s_ready=%b expected 0", s_ready);
    end
    tick();
    h_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL key_then_ready: got %b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (mul_a !== 128'h10 || mul_b !== H_X) begin
      errors++;
      $display("FAIL new_key_ops: got a=%h b=%h expected a=10 b=%h", mul_a, mul_b, H_X);
    end
    wait_tag(e);
    checks++;
    if (tag_data !== 128'h8) begin
      errors++;
      $display("FAIL new_key_tag: got %h expected 8", tag_data);
    end
    accept_tag();
  endtask

  task automatic test_clear();
    logic [127:0] a, b;
    logic st;
    int e;
    lat = 1;
    load_key(H_ID);
    send_block(128'h3, 1'b0, a, b, st);
    wait_idle();
    clr = 1'b1;
    s_valid = 1'b1;
    s_data  = 128'h4;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: got s_ready=%b expected 0", s_ready);
    end
    tick();
    clr = 1'b0;
    send_block(128'h4, 1'b1, a, b, st);
    checks++;
    if (a !== 128'h4) begin
      errors++;
      $display("FAIL clr_acc: got %h expected 4", a);
    end
    wait_tag(e);
    checks++;
    if (tag_data !== 128'h4 || blk_count !== 16'd1) begin
      errors++;
      $display("FAIL clr_tag: got tag=%h cnt=%0d expected tag=4 cnt=1", tag_data, blk_count);
    end
    accept_tag();
  endtask

  task automatic test_zero_latency();
    logic [127:0] a, b;
    logic st;
    int e;
    lat = 0;
    send_block(128'h1, 1'b0, a, b, st);
    send_block(128'h6, 1'b1, a, b, st);
    checks++;
    if (a !== 128'h7) begin
      errors++;
      $display("FAIL l0_op: got %h expected 7", a);
    end
    wait_tag(e);
    checks++;
    if (e != 1 || tag_data !== 128'h7) begin
      errors++;
      $display("FAIL l0_tag: got edges=%0d tag=%h expected edges=1 tag=7", e, tag_data);
    end
    accept_tag();
  endtask

  task automatic test_saturation();
    logic [127:0] a, b;
    logic st;
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      send_block(128'h1, 1'b0, a, b, st);
    end
    wait_idle();
    checks++;
    if (blk_count !== 16'd5 || sat_blk_count !== 2'd3) begin
      errors++;
      $display("FAIL saturation: got cnt=%0d sat=%0d expected cnt=5 sat=3", blk_count, sat_blk_count);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (blk_count !== 16'd0 || sat_blk_count !== 2'd0) begin
      errors++;
      $display("FAIL sat_clear: got cnt=%0d sat=%0d expected 0 0", blk_count, sat_blk_count);
    end
  endtask

  task automatic test_reset_midop();
    logic [127:0] a, b;
    logic st;
    lat = 8;
    send_block(128'h1, 1'b1, a, b, st);
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got busy=%b expected 0", busy);
    end
    rst_n = 1'b1;
    repeat (12) tick();
    checks++;
    if ({busy, tag_valid, h_loaded, s_ready} !== 4'b0 || blk_count !== 16'd0) begin
      errors++;
      $display("FAIL late_done: got flags=%b cnt=%0d expected 0000 0",
               {busy, tag_valid, h_loaded, s_ready}, blk_count);
    end
  endtask

  initial begin
    test_reset();
    test_identity_chain();
    test_nist();
    test_tag_stall();
    test_key_priority();
    test_clear();
    test_zero_latency();
    test_saturation();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ghash_sequencer.md
Name: ghash_sequencer

Overview:
- Sequences the GF(2^128) multiply-and-reduce datapath (KOA multiplier plus modular reduction, GCM bit order, polynomial 0xE1 || 0^120) to compute GHASH over a stream of 128-bit blocks: Y_i = (Y_{i-1} XOR X_i) * H, with Y_0 = 0.
- Owns the hash key register, the accumulator, the input/output handshakes, and the start/done protocol to the multiplier.
- Sits between the AES-GCM block formatter (upstream) and the tag XOR stage (downstream).

Parameters:
- CNT_W, 16, width of the processed-block counter (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- h_valid  in  1  load hash key; sampled only in IDLE
- h_data  in  128  hash key H
- clr  in  1  synchronous clear of accumulator and counter; honoured only in IDLE
- s_valid  in  1  input block valid
- s_ready  out  1  input block accepted when s_valid & s_ready
- s_data  in  128  input block X_i
- s_last  in  1  marks final block of a message
- mul_start  out  1  one-cycle pulse launching a multiply
- mul_a  out  128  operand A = acc XOR X_i (registered)
- mul_b  out  128  operand B = H (registered key)
- mul_done  in  1  one-cycle pulse, result valid
- mul_res  in  128  reduced product
- tag_valid  out  1  GHASH result valid
- tag_ready  in  1  downstream accepts tag
- tag_data  out  128  GHASH result
- blk_count  out  CNT_W  blocks completed in current message
- h_loaded  out  1  key has been loaded since reset
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, h_reg, mul_a, mul_b, tag_data = 0; mul_start, tag_valid, h_loaded, busy = 0; blk_count = 0.
- States: IDLE, MUL_WAIT, OUTPUT.
- IDLE:
  - s_ready = h_loaded & ~h_valid & ~clr (combinational). Key load and clear take priority over block acceptance.
  - h_valid=1: h_reg <= h_data; h_loaded <= 1; acc is unchanged.
  - clr=1: acc <= 0; blk_count <= 0.
  - On handshake: mul_a <= acc ^ s_data; mul_b <= h_reg; mul_start <= 1 for the next cycle only; last_r <= s_last; go to MUL_WAIT.
- MUL_WAIT:
  - s_ready=0. Exactly one multiply is outstanding, because each block depends on the previous accumulator value.
  - On mul_done: acc <= mul_res; blk_count <= blk_count+1, saturating at all-ones.
  - If last_r: tag_data <= mul_res; tag_valid <= 1; go to OUTPUT. Otherwise return to IDLE.
  - mul_done in the same cycle as mul_start is legal; it is treated as the done for that start.
- OUTPUT:
  - tag_valid and tag_data are held stable until tag_ready.
  - On tag_valid & tag_ready: tag_valid <= 0; acc <= 0; blk_count <= 0; go to IDLE.
- Ignored inputs:
  - mul_done outside MUL_WAIT is ignored.
  - h_valid and clr outside IDLE are ignored (not queued).
- Latency: handshake at cycle t → mul_start at t+1 → with a multiplier of latency L, mul_done at t+1+L → tag_valid (last block) or s_ready (non-last block) at t+2+L. Throughput: one block per L+2 cycles.
- mul_a and mul_b are held stable from mul_start until mul_done.
- Reset mid-operation returns to the reset state immediately. An in-flight multiplier result arriving after reset is ignored by the MUL_WAIT rule.
- An empty message is not supported. A tag is produced only after a block carrying s_last.
- No combinational path from s_valid, mul_done or tag_ready to any output except s_ready (depends on h_valid, clr).

Test Plan:
- Reset with h_valid=0 and s_valid=1 → s_ready=0, h_loaded=0, all outputs 0. Assert rst_n mid-MUL_WAIT → busy=0 next edge; a late mul_done is ignored.
- Load H=128'h8000…0 (GF identity in GCM order); send X1=128'h1, X2=128'h2, X3=128'h4 (last) with a bench multiplier model, L=3 → mul_a sequence 1, 3, 7; tag_data=128'h7; blk_count=3; each tag_valid 5 cycles after its handshake.
- Use NIST GCM test case 2 (H=66e94bd4ef8a2c3b884cfa59ca342b2e, one ciphertext block plus one length block) with the real multiply/reduce datapath → tag_data=f38cbb1ad69223dcc3457ae5b6b0f885.
- Hold tag_ready=0 for 10 cycles → tag_data stable, s_ready=0. Then raise tag_ready → acc clears and the next message starts from Y_0=0.
- In IDLE, assert h_valid and s_valid in the same cycle → s_ready=0 and the key updates; the block is accepted next cycle using the new H. Pulse mul_done in IDLE → no state or acc change.
- Run a multiplier with L=0 (mul_done concurrent with mul_start) → correct result. With CNT_W=2, send 5 blocks → blk_count saturates at 3.
